// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider (div_seq, div_step).
package div_pkg;

  // Default operand/result width and the matching iteration count.
  localparam int DIV_WIDTH     = 32;
  localparam int DIV_ITERS     = DIV_WIDTH;

  // Widest datapath this package's constants cover.
  localparam int DIV_MAX_WIDTH = 64;

  // Quotient returned on divide-by-zero (all ones, sliced to the datapath width).
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Width of an iteration counter that must hold the value iters.
  function automatic int div_cnt_w(input int iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit out of the quotient register into the partial
// remainder, trial-subtracts the divisor magnitude, and either keeps the
// difference (quotient bit 1) or restores the shifted remainder (quotient bit 0).
// This is the only subtractor in the divider.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  // The shifted remainder keeps R's top bit: with unsigned divisors above
  // 2^(WIDTH-1) the partial remainder can itself use the full width, so the
  // trial value needs WIDTH+1 bits and its difference needs a sign bit on top.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             neg;
  logic             unused_step_bits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};
  assign neg     = diff[WIDTH+1];

  // A non-negative difference is below the divisor, so it fits in WIDTH bits;
  // a negative one means the shifted remainder was already below the divisor.
  assign rem_nx  = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx  = {quo[WIDTH-2:0], ~neg};

  assign unused_step_bits = ^{diff[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for MIPS DIV/DIVU (Quotient -> LO,
// Remainder -> HI). One subtract step per cycle over WIDTH iterations; the
// pipeline stalls on Busy.
// Build option: define DIV_SIGNED_EN to honour Signed (magnitude prep, sign
// fix-up, Overflow flag). Without it every operation is DIVU, FIX is a plain
// pass-through state and Overflow is tied low.
//
// state | meaning
// IDLE  | waiting for Start; results of last operation held
// PREP  | operands latched; take magnitudes, record signs, check B == 0
// ITER  | WIDTH restoring steps, one per cycle
// FIX   | apply result signs (signed build), stage results
// DONE  | Done pulse, results valid; Start ignored here
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Overflow
);

  localparam int               ITERS   = DIV_ITERS + (WIDTH - DIV_WIDTH);
  localparam int               CNT_W   = div_cnt_w(ITERS);
  localparam logic [WIDTH-1:0] ZERO_Q  = DIV_ZERO_Q[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
  logic             sgn_q;
  logic             ovf_q;
  logic             ovf_det;

  assign a_neg   = sgn_q & a_q[WIDTH-1];
  assign b_neg   = sgn_q & b_q[WIDTH-1];
  // -2^(W-1) / -1 needs no special datapath: the magnitude of MIN_NEG is itself
  // and the natural result is Q = MIN_NEG, R = 0; only the flag is raised.
  assign ovf_det = sgn_q & (a_q == MIN_NEG) & (b_q == '1);
`else
  logic             unused_signed;

  assign a_neg         = 1'b0;
  assign b_neg         = 1'b0;
  assign unused_signed = Signed;
  assign Overflow      = 1'b0;
`endif

  assign a_mag   = a_neg ? (~a_q + ONE) : a_q;
  assign b_mag   = b_neg ? (~b_q + ONE) : b_q;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo_fix = qneg_q ? (~quo_q + ONE) : quo_q;
  assign rem_fix = rneg_q ? (~rem_q + ONE) : rem_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q     <= 1'b0;
      ovf_q     <= 1'b0;
      Overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q   <= A;
            b_q   <= B;
`ifdef DIV_SIGNED_EN
            sgn_q <= Signed;
`endif
            Busy  <= 1'b1;
            state <= PREP;
          end
        end

        PREP: begin
          if (b_q == '0) begin
            // Divide by zero bypasses the iterations entirely.
            Quotient  <= ZERO_Q;
            Remainder <= a_q;
            DivZero   <= 1'b1;
`ifdef DIV_SIGNED_EN
            Overflow  <= 1'b0;
`endif
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= DONE;
          end else begin
            rem_q  <= '0;
            quo_q  <= a_mag;
            dvs_q  <= b_mag;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
`ifdef DIV_SIGNED_EN
            ovf_q  <= ovf_det;
`endif
            cnt    <= CNT_W'(ITERS);
            state  <= ITER;
          end
        end

        ITER: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          Quotient  <= quo_fix;
          Remainder <= rem_fix;
          DivZero   <= 1'b0;
`ifdef DIV_SIGNED_EN
          Overflow  <= ovf_q;
`endif
          Busy      <= 1'b0;
          Done      <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
